arcade_input_hub: RTL and testbench
===================================

Name: arcade_input_hub

Overview:
- Parametrised successor to the per-core keyboard/joystick/DIP glue in the arcade top levels; instantiated once in emu, between hps_io and the game core.
- Decodes PS/2 key events into held-button state and ORs it with up to four MiSTer joysticks.
- Shapes coin inputs into fixed-width, debounced pulses with a coin counter.
- Captures the DIP bank (ioctl index 254) and game ID (ioctl index 1) from the MRA download.

Parameters:
- NUM_PLAYERS, 2, players served (1..4); keyboard maps P1 and P2 only, P3/P4 are joystick-only.
- COIN_PULSE, 16'd2048, coin pulse high time and post-pulse lockout time, in clk_sys cycles (>=1).
- DIP_BYTES, 8, DIP bytes captured (1..8).

Ports:
- clk_sys  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- ps2_key  in  11  hps_io key event: [10] toggle, [9] pressed, [8] extended, [7:0] scancode.
- joy  in  NUM_PLAYERS*16  joystick words, player p at [16p+15:16p], active high.
- ioctl_download  in  1  download active.
- ioctl_wr  in  1  download byte strobe.
- ioctl_index  in  8  download index.
- ioctl_addr  in  25  download byte address.
- ioctl_dout  in  8  download byte.
- btn  out  NUM_PLAYERS*8  per player, active high: [0]R [1]L [2]D [3]U [4]F1 [5]F2 [6]F3 [7]F4.
- start  out  NUM_PLAYERS  start buttons, active high.
- coin  out  NUM_PLAYERS  shaped coin pulses, active high.
- coin_count  out  16  total accepted coins, all players.
- dip  out  DIP_BYTES*8  DIP bytes, byte i at [8i+7:8i].
- game_id  out  8  game ID byte.

Behaviour:
Key decode:
- Register ps2_key[10] each cycle. A key event is a cycle where ps2_key[10] differs from the registered copy; exactly one event per toggle.
- Match on ps2_key[7:0] only; the extended bit is ignored.
- On an event, the mapped held bit takes the value of ps2_key[9]. Unmapped codes are ignored.
- P1 map: 74 R, 6B L, 72 D, 75 U, 14 F1, 11 F2, 29 F3, 12 F4, 05/16 start, 76/2E coin.
- P2 map: 34 R, 23 L, 2B D, 2D U, 1C F1, 1B F2, 15 F3, 1D F4, 06/1E start, 36 coin.
- Two codes mapped to the same bit share that bit; the last event wins.
- If NUM_PLAYERS=1, the P2 map is ignored.

Output combine:
- btn, start and raw coin are registered: output = held-key bit OR joystick bit.
- Joystick sources: btn[7:0] = joy[7:4,3:0] ordering as listed (F1..F4 = joy[4..7]); start = joy[8]; raw coin = joy[9].
- Latency: one clk_sys cycle from key event or joystick change to btn/start.

Coin shaper, one per player, states IDLE/PULSE/GAP with a 16-bit down-counter:
- IDLE: on a raw-coin rising edge (raw coin registered once for edge detect), enter PULSE, load counter with COIN_PULSE-1, set coin=1, increment coin_count.
- PULSE: coin=1 for exactly COIN_PULSE cycles, then enter GAP, reload counter, set coin=0.
- GAP: lasts COIN_PULSE cycles, then return to IDLE.
- Rising edges during PULSE/GAP are discarded, not queued. A coin held continuously produces one pulse.
- coin_count wraps FFFF->0000. If several players enter PULSE in the same cycle, coin_count increments by the number of players entering.

Loader:
- Writes when ioctl_wr=1.
- index 254 with ioctl_addr[24:3]=0 and ioctl_addr[2:0]<DIP_BYTES: dip byte [addr[2:0]] <= ioctl_dout.
- index 1: game_id <= ioctl_dout, at any address; the last byte written wins.
- The loader operates regardless of reset, because emu holds reset during download.

Reset:
- Clears all held keys, btn, start, coin, coin_count, shaper state (IDLE) and the registered toggle (loaded with the current ps2_key[10], so no spurious event).
- dip and game_id are not affected by reset. Their power-up values are dip all 8'hFF and game_id 8'hFF.
- Reset mid-PULSE forces coin=0 and IDLE on the next edge; a coin still held after reset does not produce a pulse until it is released and pressed again.

Test Plan:
- Toggle ps2_key[10] with {pressed=1, code 14}, then {pressed=0, code 14} -> btn[4] goes 1 one cycle after the first event and 0 one cycle after the second; no other btn bit changes.
- Set joy[15:0]=0x0001 while key 6B is held -> btn[1:0]=2'b11; change ps2_key with no toggle -> no state change.
- COIN_PULSE=4, joy[9] high for 20 cycles -> coin high exactly 4 cycles, then low, and coin_count=1.
- Second rising edge during GAP -> no pulse; rising edge after GAP -> second pulse and coin_count=2.
- P1 and P2 coin rising edges on the same cycle (NUM_PLAYERS=2) -> both coin bits pulse and coin_count increments by 2.
- Download index 254 bytes 0..7 = 0x10..0x17 with reset held, then a byte at addr 8, then an index 1 byte 0x03, then reset -> dip=0x1716151413121110, addr 8 ignored, game_id=03, both retained after reset.

Source files
------------

// File: rtl/arcade_input_hub.sv
// ---------------------------------------------------------------------------
// arcade_input_hub
//
// Shared input glue that sits between hps_io and an arcade game core.
//   - Turns PS/2 key events into held-button state for players 1 and 2 and
//     ORs that state with up to four MiSTer joystick words.
//   - Turns each player's raw coin input into a fixed-width coin pulse
//     followed by a lockout gap, and keeps a running count of accepted coins.
//   - Captures the DIP switch bank (download index 254) and the game ID byte
//     (download index 1) from the MRA download stream.
//
// Parameters:
//   NUM_PLAYERS  players served (1..4); only P1/P2 have keyboard mappings
//   COIN_PULSE   coin pulse high time and post-pulse lockout, in clk_sys cycles
//   DIP_BYTES    number of DIP bytes captured (1..8)
//
// Ports:
//   clk_sys         system clock
//   reset           synchronous, active-high reset
//   ps2_key         [10] toggle, [9] pressed, [8] extended, [7:0] scancode
//   joy             joystick words, player p at [16p+15:16p], active high
//   ioctl_download  download in progress (not needed by the loader)
//   ioctl_wr        download byte strobe
//   ioctl_index     download index
//   ioctl_addr      download byte address
//   ioctl_dout      download byte
//   btn             per player [0]R [1]L [2]D [3]U [4]F1 [5]F2 [6]F3 [7]F4
//   start           per-player start buttons
//   coin            per-player shaped coin pulses
//   coin_count      total accepted coins over all players, wraps at 16 bits
//   dip             DIP bytes, byte i at [8i+7:8i]
//   game_id         game ID byte
// ---------------------------------------------------------------------------
module arcade_input_hub #(
    parameter int          NUM_PLAYERS = 2,
    parameter logic [15:0] COIN_PULSE  = 16'd2048,
    parameter int          DIP_BYTES   = 8
) (
    input  logic                     clk_sys,
    input  logic                     reset,
    input  logic [10:0]              ps2_key,
    input  logic [NUM_PLAYERS*16-1:0] joy,
    input  logic                     ioctl_download,
    input  logic                     ioctl_wr,
    input  logic [7:0]               ioctl_index,
    input  logic [24:0]              ioctl_addr,
    input  logic [7:0]               ioctl_dout,
    output logic [NUM_PLAYERS*8-1:0] btn,
    output logic [NUM_PLAYERS-1:0]   start,
    output logic [NUM_PLAYERS-1:0]   coin,
    output logic [15:0]              coin_count,
    output logic [DIP_BYTES*8-1:0]   dip,
    output logic [7:0]               game_id
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } coin_state_t;

    // Held key bits for P1/P2: [7:0] buttons, [8] start, [9] coin.
    logic [9:0]             held_q    [0:1];
    logic [9:0]             held_next [0:1];

    logic                   toggle_q;
    logic                   key_event;
    logic                   key_hit;
    logic                   key_player;
    logic [3:0]             key_bit;

    logic [NUM_PLAYERS*8-1:0] btn_next;
    logic [NUM_PLAYERS-1:0] start_next;
    logic [NUM_PLAYERS-1:0] raw_coin_next;
    logic [NUM_PLAYERS-1:0] joy_coin;
    logic [NUM_PLAYERS-1:0] raw_coin;
    logic [NUM_PLAYERS-1:0] raw_coin_prev;
    logic [NUM_PLAYERS-1:0] coin_rise;
    logic [NUM_PLAYERS-1:0] coin_enter;
    logic [2:0]             enter_total;

    // Power-up contents of the download-loaded registers; reset never touches them.
    logic [DIP_BYTES*8-1:0] dip_q     = '1;
    logic [7:0]             game_id_q = 8'hFF;

    // Inputs the loader or decoder deliberately ignore (download flag, the
    // extended-key bit, unassigned joystick bits) are folded here.
    logic                   unused_bits;
    assign unused_bits = ^{ioctl_download, ps2_key[8], joy};

    // hps_io flips ps2_key[10] once per key event, so comparing it with last
    // cycle's copy yields exactly one event per toggle.
    assign key_event = ps2_key[10] ^ toggle_q;

    // Scancode lookup: which player and which held bit a code drives. The
    // extended bit is ignored, so E0-prefixed cursor keys share the mapping.
    always_comb begin
        key_hit    = 1'b1;
        key_player = 1'b0;
        key_bit    = 4'd0;
        case (ps2_key[7:0])
            8'h74: key_bit = 4'd0;
            8'h6B: key_bit = 4'd1;
            8'h72: key_bit = 4'd2;
            8'h75: key_bit = 4'd3;
            8'h14: key_bit = 4'd4;
            8'h11: key_bit = 4'd5;
            8'h29: key_bit = 4'd6;
            8'h12: key_bit = 4'd7;
            8'h05, 8'h16: key_bit = 4'd8;
            8'h76, 8'h2E: key_bit = 4'd9;
            8'h34: begin key_player = 1'b1; key_bit = 4'd0; end
            8'h23: begin key_player = 1'b1; key_bit = 4'd1; end
            8'h2B: begin key_player = 1'b1; key_bit = 4'd2; end
            8'h2D: begin key_player = 1'b1; key_bit = 4'd3; end
            8'h1C: begin key_player = 1'b1; key_bit = 4'd4; end
            8'h1B: begin key_player = 1'b1; key_bit = 4'd5; end
            8'h15: begin key_player = 1'b1; key_bit = 4'd6; end
            8'h1D: begin key_player = 1'b1; key_bit = 4'd7; end
            8'h06, 8'h1E: begin key_player = 1'b1; key_bit = 4'd8; end
            8'h36: begin key_player = 1'b1; key_bit = 4'd9; end
            default: key_hit = 1'b0;
        endcase
        if (key_player && (NUM_PLAYERS < 2)) begin
            key_hit = 1'b0;
        end
    end

    // Next held-key state. The outputs are registered from this next value
    // so a key event shows on btn/start one cycle later, not two.
    always_comb begin
        held_next = held_q;
        if (key_event && key_hit) begin
            held_next[key_player][key_bit] = ps2_key[9];
        end
    end

    // Key state, toggle copy and the registered button/start/raw-coin lines.
    // On reset the toggle copy follows ps2_key[10] so no event appears when
    // reset drops. The raw-coin history is set to "was high" so a coin held
    // through reset must be released before it can count again.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            toggle_q      <= ps2_key[10];
            held_q        <= '{default: '0};
            btn           <= '0;
            start         <= '0;
            raw_coin      <= joy_coin;
            raw_coin_prev <= '1;
        end else begin
            toggle_q      <= ps2_key[10];
            held_q        <= held_next;
            btn           <= btn_next;
            start         <= start_next;
            raw_coin      <= raw_coin_next;
            raw_coin_prev <= raw_coin;
        end
    end

    assign coin_rise = raw_coin & ~raw_coin_prev;

    // Per-player combine and coin shaper.
    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
        logic [9:0]  key_src;
        coin_state_t state_q;
        coin_state_t state_next;
        logic [15:0] cnt_q;
        logic [15:0] cnt_next;
        logic        enter;

        if (p < 2) begin : g_keyboard
            assign key_src = held_next[p];
        end else begin : g_joy_only
            assign key_src = '0;
        end

        assign btn_next[8*p +: 8] = key_src[7:0] | joy[16*p +: 8];
        assign start_next[p]      = key_src[8] | joy[16*p + 8];
        assign raw_coin_next[p]   = key_src[9] | joy[16*p + 9];
        assign joy_coin[p]        = joy[16*p + 9];

        // Shaper state register; reset abandons any pulse in progress.
        always_ff @(posedge clk_sys) begin
            if (reset) begin
                state_q <= IDLE;
                cnt_q   <= '0;
            end else begin
                state_q <= state_next;
                cnt_q   <= cnt_next;
            end
        end

        // The counter runs COIN_PULSE-1 down to 0 in both PULSE and GAP, so
        // each phase lasts exactly COIN_PULSE cycles. Edges outside IDLE are
        // dropped rather than remembered.
        always_comb begin
            state_next = state_q;
            cnt_next   = cnt_q;
            enter      = 1'b0;
            case (state_q)
                IDLE: begin
                    if (coin_rise[p]) begin
                        state_next = PULSE;
                        cnt_next   = COIN_PULSE - 16'd1;
                        enter      = 1'b1;
                    end
                end
                PULSE: begin
                    if (cnt_q == 16'd0) begin
                        state_next = GAP;
                        cnt_next   = COIN_PULSE - 16'd1;
                    end else begin
                        cnt_next = cnt_q - 16'd1;
                    end
                end
                GAP: begin
                    if (cnt_q == 16'd0) begin
                        state_next = IDLE;
                    end else begin
                        cnt_next = cnt_q - 16'd1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end

        assign coin_enter[p] = enter;
        assign coin[p]       = (state_q == PULSE);
    end

    // Several players may start a pulse on the same edge; all are counted.
    always_comb begin
        enter_total = 3'd0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            enter_total = enter_total + 3'(coin_enter[p]);
        end
    end

    // Coin counter, free-running with 16-bit wrap.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            coin_count <= '0;
        end else begin
            coin_count <= coin_count + {13'd0, enter_total};
        end
    end

    // Download capture. No reset here: emu holds reset for the whole
    // download, and the captured settings must survive it.
    always_ff @(posedge clk_sys) begin
        if (ioctl_wr) begin
            if ((ioctl_index == 8'd254) && (ioctl_addr[24:3] == '0)) begin
                for (int i = 0; i < DIP_BYTES; i++) begin
                    if (ioctl_addr[2:0] == 3'(i)) begin
                        dip_q[8*i +: 8] <= ioctl_dout;
                    end
                end
            end
            if (ioctl_index == 8'd1) begin
                game_id_q <= ioctl_dout;
            end
        end
    end

    assign dip     = dip_q;
    assign game_id = game_id_q;

endmodule

// File: tb/tb_arcade_input_hub.sv
// ---------------------------------------------------------------------------
// tb_arcade_input_hub
//
// Drives arcade_input_hub (2 players, 4-cycle coin pulse, 8 DIP bytes) with a
// directed vector table, hand-written coin/loader sequences and a random
// phase. A reference model tracks held keys, coin pulse windows and the
// download registers from the behavioural rules and is compared every cycle.
// ---------------------------------------------------------------------------
module tb_arcade_input_hub;

    localparam int NP        = 2;
    localparam int PULSE_LEN = 4;
    localparam int DB        = 8;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic [10:0] ps2_key;
    logic [31:0] joy;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [7:0]  ioctl_index;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic [15:0] btn;
    logic [1:0]  start;
    logic [1:0]  coin;
    logic [15:0] coin_count;
    logic [63:0] dip;
    logic [7:0]  game_id;

    int checks = 0;
    int errors = 0;

    arcade_input_hub #(
        .NUM_PLAYERS(NP),
        .COIN_PULSE (16'(PULSE_LEN)),
        .DIP_BYTES  (DB)
    ) dut (
        .clk_sys       (clk_sys),
        .reset         (reset),
        .ps2_key       (ps2_key),
        .joy           (joy),
        .ioctl_download(ioctl_download),
        .ioctl_wr      (ioctl_wr),
        .ioctl_index   (ioctl_index),
        .ioctl_addr    (ioctl_addr),
        .ioctl_dout    (ioctl_dout),
        .btn           (btn),
        .start         (start),
        .coin          (coin),
        .coin_count    (coin_count),
        .dip           (dip),
        .game_id       (game_id)
    );

    // 10 ns system clock.
    always #5 clk_sys = ~clk_sys;

    // Key map as a lookup table: code, player, held bit (8 = start, 9 = coin).
    logic [7:0] mapCode   [23] = '{8'h74, 8'h6B, 8'h72, 8'h75, 8'h14, 8'h11, 8'h29, 8'h12,
                                   8'h05, 8'h16, 8'h76, 8'h2E,
                                   8'h34, 8'h23, 8'h2B, 8'h2D, 8'h1C, 8'h1B, 8'h15, 8'h1D,
                                   8'h06, 8'h1E, 8'h36};
    int         mapPlayer [23] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                                   1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
    int         mapBit    [23] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 8, 9, 9,
                                   0, 1, 2, 3, 4, 5, 6, 7, 8, 8, 9};

    // Reference model state.
    logic [9:0]  mHeld [2];
    logic        mPrevTog;
    logic [1:0]  mRaw;
    logic [1:0]  mRawPrev;
    int          mPulseStart [2] = '{-100, -100};
    int          mFreeAt [2] = '{0, 0};
    int          cyc = 0;
    logic [15:0] mCount = 16'd0;
    logic [7:0]  mDip [8] = '{default: 8'hFF};
    logic [7:0]  mGid = 8'hFF;

    logic [15:0] expBtn;
    logic [1:0]  expStart;
    logic [1:0]  expCoin;
    logic [63:0] expDip;

    // Directed vectors for key decode and joystick merge.
    typedef struct {
        logic        tog;
        logic        pressed;
        logic        ext;
        logic [7:0]  code;
        logic [31:0] joyVal;
        logic [15:0] expBtn;
        logic [1:0]  expStart;
    } vec_t;

    vec_t vecs [15];

    int highs;
    int highs1;
    int bothSeen;
    int idx;

    // Single comparison with failure reporting.
    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Model of one clock edge using the inputs currently applied.
    task automatic modelEdge();
        cyc++;
        if (ioctl_wr) begin
            if (ioctl_index == 8'd254 && ioctl_addr < 25'd8) mDip[ioctl_addr[2:0]] = ioctl_dout;
            if (ioctl_index == 8'd1) mGid = ioctl_dout;
        end
        if (reset) begin
            mHeld[0]       = '0;
            mHeld[1]       = '0;
            mPrevTog       = ps2_key[10];
            mRaw           = {joy[25], joy[9]};
            mRawPrev       = 2'b11;
            mPulseStart[0] = -100;
            mPulseStart[1] = -100;
            mFreeAt[0]     = 0;
            mFreeAt[1]     = 0;
            mCount         = 16'd0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (mRaw[p] && !mRawPrev[p] && cyc >= mFreeAt[p]) begin
                    mPulseStart[p] = cyc;
                    mFreeAt[p]     = cyc + 2 * PULSE_LEN + 1;
                    mCount         = mCount + 16'd1;
                end
            end
            if (ps2_key[10] != mPrevTog) begin
                for (int i = 0; i < 23; i++) begin
                    if (mapCode[i] == ps2_key[7:0]) mHeld[mapPlayer[i]][mapBit[i]] = ps2_key[9];
                end
            end
            mPrevTog = ps2_key[10];
            mRawPrev = mRaw;
            for (int p = 0; p < 2; p++) mRaw[p] = mHeld[p][9] | joy[16*p + 9];
        end
        for (int p = 0; p < 2; p++) begin
            expBtn[8*p +: 8] = reset ? 8'h00 : (mHeld[p][7:0] | joy[16*p +: 8]);
            expStart[p]      = reset ? 1'b0 : (mHeld[p][8] | joy[16*p + 8]);
            expCoin[p]       = (cyc >= mPulseStart[p]) && (cyc < mPulseStart[p] + PULSE_LEN);
        end
        for (int i = 0; i < 8; i++) expDip[8*i +: 8] = mDip[i];
    endtask

    // Compare every output against the model.
    task automatic checkModel();
        checkOutput("model_btn", 64'(btn), 64'(expBtn));
        checkOutput("model_start", 64'(start), 64'(expStart));
        checkOutput("model_coin", 64'(coin), 64'(expCoin));
        checkOutput("model_coin_count", 64'(coin_count), 64'(mCount));
        checkOutput("model_dip", dip, expDip);
        checkOutput("model_game_id", 64'(game_id), 64'(mGid));
    endtask

    // One clock with the current inputs; outputs sampled 1 ns after the edge.
    task automatic applyStimulus();
        @(posedge clk_sys);
        modelEdge();
        #1;
        checkModel();
    endtask

    // Main sequence.
    initial begin
        reset          = 1'b1;
        ps2_key        = '0;
        joy            = '0;
        ioctl_download = 1'b0;
        ioctl_wr       = 1'b0;
        ioctl_index    = '0;
        ioctl_addr     = '0;
        ioctl_dout     = '0;

        vecs[0]  = '{1'b0, 1'b0, 1'b0, 8'h00, 32'h0000_0000, 16'h0000, 2'b00};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 8'h14, 32'h0000_0000, 16'h0010, 2'b00};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 8'h14, 32'h0000_0000, 16'h0010, 2'b00};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 8'h14, 32'h0000_0000, 16'h0000, 2'b00};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 8'h6B, 32'h0000_0000, 16'h0002, 2'b00};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 8'h6B, 32'h0000_0001, 16'h0003, 2'b00};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 8'h6B, 32'h0000_0001, 16'h0003, 2'b00};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 8'h34, 32'h0000_0000, 16'h0102, 2'b00};
        vecs[8]  = '{1'b1, 1'b1, 1'b1, 8'h05, 32'h0000_0000, 16'h0102, 2'b01};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 8'h16, 32'h0000_0000, 16'h0102, 2'b00};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 8'h1E, 32'h0000_0000, 16'h0102, 2'b10};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 8'h55, 32'h0000_0000, 16'h0102, 2'b10};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 8'h55, 32'h0000_0100, 16'h0102, 2'b11};
        vecs[13] = '{1'b1, 1'b0, 1'b0, 8'h6B, 32'h0020_0000, 16'h2100, 2'b10};
        vecs[14] = '{1'b0, 1'b1, 1'b0, 8'h2D, 32'h0000_0000, 16'h0900, 2'b10};

        // Power-up and reset state.
        applyStimulus();
        checkOutput("powerup_dip", dip, 64'hFFFF_FFFF_FFFF_FFFF);
        checkOutput("powerup_game_id", 64'(game_id), 64'hFF);
        repeat (2) applyStimulus();
        checkOutput("reset_btn", 64'(btn), 64'h0);
        checkOutput("reset_coin_count", 64'(coin_count), 64'h0);

        // Directed key-decode / joystick-merge table.
        reset = 1'b0;
        for (int i = 0; i < 15; i++) begin
            ps2_key = {vecs[i].tog, vecs[i].pressed, vecs[i].ext, vecs[i].code};
            joy     = vecs[i].joyVal;
            applyStimulus();
            checkOutput($sformatf("vec%0d_btn", i), 64'(btn), 64'(vecs[i].expBtn));
            checkOutput($sformatf("vec%0d_start", i), 64'(start), 64'(vecs[i].expStart));
        end

        // Reset clears held keys; a toggle flipped during reset is no event.
        reset   = 1'b1;
        ps2_key = {1'b1, 1'b1, 1'b0, 8'h14};
        applyStimulus();
        checkOutput("rst_btn_cleared", 64'(btn), 64'h0);
        checkOutput("rst_start_cleared", 64'(start), 64'h0);
        reset = 1'b0;
        applyStimulus();
        checkOutput("rst_no_spurious_event", 64'(btn), 64'h0);

        // Coin held for 20 cycles gives one 4-cycle pulse.
        reset = 1'b1; applyStimulus(); reset = 1'b0;
        highs = 0;
        joy = 32'h0000_0200;
        repeat (20) begin applyStimulus(); highs += int'(coin[0]); end
        joy = 32'h0;
        repeat (12) begin applyStimulus(); highs += int'(coin[0]); end
        checkOutput("held_coin_high_cycles", 64'(highs), 64'd4);
        checkOutput("held_coin_count", 64'(coin_count), 64'd1);

        // Edge during GAP is dropped; edge after GAP gives a second pulse.
        reset = 1'b1; applyStimulus(); reset = 1'b0;
        highs = 0;
        for (int i = 0; i < 20; i++) begin
            joy = (i == 0 || i == 6) ? 32'h0000_0200 : 32'h0;
            applyStimulus();
            highs += int'(coin[0]);
        end
        checkOutput("gap_edge_high_cycles", 64'(highs), 64'd4);
        checkOutput("gap_edge_count", 64'(coin_count), 64'd1);
        highs = 0;
        for (int i = 0; i < 20; i++) begin
            joy = (i == 0) ? 32'h0000_0200 : 32'h0;
            applyStimulus();
            highs += int'(coin[0]);
        end
        checkOutput("second_pulse_high_cycles", 64'(highs), 64'd4);
        checkOutput("second_pulse_count", 64'(coin_count), 64'd2);

        // Reset mid-pulse, coin held through reset, then released and re-pressed.
        reset = 1'b1; applyStimulus(); reset = 1'b0;
        joy = 32'h0000_0200;
        repeat (3) applyStimulus();
        checkOutput("midpulse_coin_high", 64'(coin[0]), 64'd1);
        reset = 1'b1; applyStimulus();
        checkOutput("midpulse_reset_coin", 64'(coin[0]), 64'd0);
        reset = 1'b0;
        highs = 0;
        repeat (12) begin applyStimulus(); highs += int'(coin[0]); end
        checkOutput("held_through_reset_no_pulse", 64'(highs), 64'd0);
        joy = 32'h0;
        repeat (2) applyStimulus();
        joy = 32'h0000_0200;
        highs = 0;
        repeat (12) begin applyStimulus(); highs += int'(coin[0]); end
        checkOutput("repress_after_reset_pulse", 64'(highs), 64'd4);
        checkOutput("repress_after_reset_count", 64'(coin_count), 64'd1);

        // P1 and P2 coin edges on the same cycle.
        joy = 32'h0;
        reset = 1'b1; applyStimulus(); reset = 1'b0;
        repeat (2) applyStimulus();
        bothSeen = 0;
        highs = 0;
        highs1 = 0;
        joy = 32'h0200_0200;
        repeat (3) begin
            applyStimulus();
            if (coin == 2'b11) bothSeen = 1;
            highs += int'(coin[0]); highs1 += int'(coin[1]);
        end
        joy = 32'h0;
        repeat (12) begin
            applyStimulus();
            if (coin == 2'b11) bothSeen = 1;
            highs += int'(coin[0]); highs1 += int'(coin[1]);
        end
        checkOutput("dual_coin_both_high", 64'(bothSeen), 64'd1);
        checkOutput("dual_coin_p1_cycles", 64'(highs), 64'd4);
        checkOutput("dual_coin_p2_cycles", 64'(highs1), 64'd4);
        checkOutput("dual_coin_count", 64'(coin_count), 64'd2);

        // Download under reset: DIP bytes, an out-of-range address, a game ID.
        reset = 1'b1;
        ioctl_download = 1'b1;
        for (int i = 0; i < 8; i++) begin
            ioctl_wr = 1'b1; ioctl_index = 8'd254;
            ioctl_addr = 25'(i); ioctl_dout = 8'(8'h10 + i);
            applyStimulus();
        end
        ioctl_addr = 25'd8; ioctl_dout = 8'hEE;
        applyStimulus();
        ioctl_index = 8'd1; ioctl_addr = 25'h123; ioctl_dout = 8'h03;
        applyStimulus();
        ioctl_wr = 1'b0; ioctl_download = 1'b0;
        reset = 1'b0; applyStimulus();
        reset = 1'b1; applyStimulus();
        reset = 1'b0; applyStimulus();
        checkOutput("loader_dip", dip, 64'h1716_1514_1312_1110);
        checkOutput("loader_game_id", 64'(game_id), 64'h03);

        // Random phase against the reference model.
        for (int n = 0; n < 2500; n++) begin
            reset = ($urandom_range(0, 249) == 0);
            if ($urandom_range(0, 3) == 0) begin
                ps2_key[10]  = ~ps2_key[10];
                ps2_key[9]   = 1'($urandom);
                ps2_key[8]   = 1'($urandom);
                ps2_key[7:0] = ($urandom_range(0, 4) == 0) ? 8'h55 : mapCode[$urandom_range(0, 22)];
            end else if ($urandom_range(0, 3) == 0) begin
                ps2_key[9:0] = 10'($urandom);
            end
            if ($urandom_range(0, 5) == 0) begin
                idx = int'($urandom_range(0, 31));
                joy[idx] = ~joy[idx];
            end
            ioctl_wr = ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 2))
                0: ioctl_index = 8'd1;
                1: ioctl_index = 8'd254;
                default: ioctl_index = 8'd7;
            endcase
            ioctl_addr = 25'($urandom_range(0, 11)) |
                         (($urandom_range(0, 5) == 0) ? 25'h80_0000 : 25'h0);
            ioctl_dout = 8'($urandom);
            applyStimulus();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
